// File: rtl/axi_ram_cmd_backend.sv
// RAM-side responder: executes strobed writes / reads from the shared command stream.
// Read latency: accept in N, response valid in N+2 at the earliest; writes produce no response.
// Backpressure: command ready drops once queued + inflight reads fill the response FIFO.

module axi_ram_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  output logic [WIDTH-1:0]         out_dat,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count
);
  // Show-ahead FIFO with no full flag: the producer never pushes without a credit.
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (in_vld && !pop)      count <= count + 1'b1;
      else if (!in_vld && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld) mem[wr_ptr] <= in_dat;
  end
endmodule

module axi_ram_cmd_backend #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int STRB_WIDTH       = DATA_WIDTH/8,
  parameter int ID_WIDTH         = 8,
  parameter int AUSER_WIDTH      = 1,
  parameter int RUSER_ENABLE     = 0,
  parameter int RUSER_WIDTH      = 1,
  parameter int VALID_ADDR_WIDTH = ADDR_WIDTH-$clog2(STRB_WIDTH),
  parameter int RESP_FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ID_WIDTH-1:0]    ram_cmd_id,
  input  logic [ADDR_WIDTH-1:0]  ram_cmd_addr,
  input  logic [AUSER_WIDTH-1:0] ram_cmd_auser,
  input  logic [DATA_WIDTH-1:0]  ram_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb,
  input  logic                   ram_cmd_wr_en,
  input  logic                   ram_cmd_rd_en,
  input  logic                   ram_cmd_last,
  output logic                   ram_cmd_ready,
  output logic [ID_WIDTH-1:0]    ram_rd_resp_id,
  output logic [DATA_WIDTH-1:0]  ram_rd_resp_data,
  output logic                   ram_rd_resp_last,
  output logic [RUSER_WIDTH-1:0] ram_rd_resp_user,
  output logic                   ram_rd_resp_valid,
  input  logic                   ram_rd_resp_ready
);
  localparam int OFS = $clog2(STRB_WIDTH);
  localparam int CW  = $clog2(RESP_FIFO_DEPTH) + 1;
  localparam int UW  = (AUSER_WIDTH < RUSER_WIDTH) ? AUSER_WIDTH : RUSER_WIDTH;

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [DATA_WIDTH-1:0]  data;
    logic                   last;
    logic [RUSER_WIDTH-1:0] user;
  } resp_t;

  logic [DATA_WIDTH-1:0]       mem [2**VALID_ADDR_WIDTH];
  logic [VALID_ADDR_WIDTH-1:0] idx;
  logic                        wr_acc;
  logic                        rd_acc;
  logic                        inflight;
  resp_t                       rd_q;
  resp_t                       resp_head;
  logic [RUSER_WIDTH-1:0]      user_rs;
  logic [CW-1:0]               fifo_count;
  logic [CW:0]                 credit_used;
  logic                        unused_bits;

  assign idx    = ram_cmd_addr[OFS +: VALID_ADDR_WIDTH];
  assign wr_acc = ram_cmd_wr_en && ram_cmd_ready;
  // A simultaneous write wins; the read is dropped.
  assign rd_acc = ram_cmd_rd_en && ram_cmd_ready && !ram_cmd_wr_en;

  always_comb begin
    user_rs = '0;
    if (RUSER_ENABLE != 0) user_rs[UW-1:0] = ram_cmd_auser[UW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (ram_cmd_wr_strb[b]) mem[idx][8*b +: 8] <= ram_cmd_wr_data[8*b +: 8];
      end
    end
    if (rd_acc) begin
      rd_q.data <= mem[idx];
      rd_q.id   <= ram_cmd_id;
      rd_q.last <= ram_cmd_last;
      rd_q.user <= user_rs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rd_acc;
  end

  axi_ram_cmd_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (inflight),
    .in_dat  (rd_q),
    .out_vld (ram_rd_resp_valid),
    .out_dat (resp_head),
    .out_rdy (ram_rd_resp_ready),
    .count   (fifo_count)
  );

  // Credits count the inflight read too, so the push one cycle later always fits.
  assign credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign ram_cmd_ready = credit_used < (CW+1)'(RESP_FIFO_DEPTH);

  assign ram_rd_resp_id   = resp_head.id;
  assign ram_rd_resp_data = resp_head.data;
  assign ram_rd_resp_last = resp_head.last;
  assign ram_rd_resp_user = resp_head.user;

  assign unused_bits = ^{ram_cmd_addr, ram_cmd_auser};
endmodule

// File: tb/tb_axi_ram_cmd_backend.sv
// Bench for axi_ram_cmd_backend: vector table, hand sequences and a random run against a queue model.
module tb_axi_ram_cmd_backend;
  localparam int DEPTH = 4;
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_id = '0;
  logic [15:0] cmd_addr = '0;
  logic [0:0]  cmd_auser = '0;
  logic [31:0] cmd_wr_data = '0;
  logic [3:0]  cmd_wr_strb = '0;
  logic        cmd_wr_en = 1'b0;
  logic        cmd_rd_en = 1'b0;
  logic        cmd_last = 1'b0;
  logic        cmd_ready;
  logic [7:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_last;
  logic [0:0]  resp_user;
  logic        resp_valid;
  logic        resp_ready = 1'b1;

  logic [7:0]  u2_id = '0;
  logic [15:0] u2_addr = '0;
  logic [3:0]  u2_auser = '0;
  logic        u2_rd_en = 1'b0;
  logic        u2_cmd_ready;
  logic [7:0]  u2_resp_id;
  logic [31:0] u2_resp_data;
  logic        u2_resp_last;
  logic [1:0]  u2_resp_user;
  logic        u2_resp_valid;

  always #5 clk = ~clk;

  axi_ram_cmd_backend #(.VALID_ADDR_WIDTH(6), .RESP_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_cmd_id(cmd_id), .ram_cmd_addr(cmd_addr), .ram_cmd_auser(cmd_auser),
    .ram_cmd_wr_data(cmd_wr_data), .ram_cmd_wr_strb(cmd_wr_strb),
    .ram_cmd_wr_en(cmd_wr_en), .ram_cmd_rd_en(cmd_rd_en), .ram_cmd_last(cmd_last),
    .ram_cmd_ready(cmd_ready),
    .ram_rd_resp_id(resp_id), .ram_rd_resp_data(resp_data), .ram_rd_resp_last(resp_last),
    .ram_rd_resp_user(resp_user), .ram_rd_resp_valid(resp_valid), .ram_rd_resp_ready(resp_ready)
  );

  axi_ram_cmd_backend #(.AUSER_WIDTH(4), .RUSER_ENABLE(1), .RUSER_WIDTH(2), .VALID_ADDR_WIDTH(4)) dut_user (
    .clk(clk), .rst_n(rst_n),
    .ram_cmd_id(u2_id), .ram_cmd_addr(u2_addr), .ram_cmd_auser(u2_auser),
    .ram_cmd_wr_data(32'h0), .ram_cmd_wr_strb(4'h0),
    .ram_cmd_wr_en(1'b0), .ram_cmd_rd_en(u2_rd_en), .ram_cmd_last(1'b1),
    .ram_cmd_ready(u2_cmd_ready),
    .ram_rd_resp_id(u2_resp_id), .ram_rd_resp_data(u2_resp_data), .ram_rd_resp_last(u2_resp_last),
    .ram_rd_resp_user(u2_resp_user), .ram_rd_resp_valid(u2_resp_valid), .ram_rd_resp_ready(1'b1)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_resp = 0;
  int n_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: word array plus an in-order queue of outstanding reads.
  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  logic [31:0] mdl_mem [WORDS];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && cmd_wr_en && cmd_rd_en) $error("wr_en and rd_en asserted together");
  end

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!rst_n) begin
      q.delete();
    end else begin
      check("mdl_ready", cmd_ready, q.size() < DEPTH);
      check("mdl_valid", resp_valid, q.size() > 0 && q[0].cyc <= cyc - 2);
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          check("mdl_unexpected_resp", resp_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("mdl_data", resp_data, e.data);
          check("mdl_id", resp_id, e.id);
          check("mdl_last", resp_last, e.last);
          check("mdl_user", resp_user, 1'b0);
          n_resp++;
          if (resp_last) n_last++;
        end
      end
      a = (int'(cmd_addr) / 4) % WORDS;
      if (cmd_ready && cmd_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (cmd_wr_strb[b]) mdl_mem[a][8*b +: 8] = cmd_wr_data[8*b +: 8];
      end else if (cmd_ready && cmd_rd_en) begin
        q.push_back('{cmd_id, mdl_mem[a], cmd_last, cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [7:0] i, input logic l);
    cmd_wr_en = wr; cmd_rd_en = rd; cmd_addr = a; cmd_wr_data = d;
    cmd_wr_strb = s; cmd_id = i; cmd_last = l;
  endtask

  task automatic idle();
    cmd_wr_en = 1'b0;
    cmd_rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    idle();
    resp_ready = 1'b1;
    while (q.size() != 0 && t < 100) begin tick(); t++; end
    check(name, q.size(), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  id;
    logic        last;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int n0, l0, t;
    vecs[0]  = '{1'b1, 16'h0014, 32'hAABBCCDD, 4'hF, 8'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 16'h0014, 32'h11223344, 4'h5, 8'h00, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 16'h0014, 32'h0,        4'h0, 8'h11, 1'b1, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 16'h0004, 32'hCAFEF00D, 4'hF, 8'h00, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 16'h0104, 32'h0,        4'h0, 8'h22, 1'b0, 32'hCAFEF00D};
    vecs[5]  = '{1'b0, 16'h0006, 32'h0,        4'h0, 8'h23, 1'b1, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 16'h0014, 32'hFFFFFFFF, 4'h0, 8'h00, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 16'h0017, 32'h0,        4'h0, 8'h24, 1'b0, 32'hAA22CC44};
    vecs[8]  = '{1'b1, 16'h0024, 32'h12345678, 4'hF, 8'h00, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 16'h0024, 32'h9A000000, 4'h8, 8'h00, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 16'hFF24, 32'h0,        4'h0, 8'h25, 1'b1, 32'h9A345678};
    vecs[11] = '{1'b0, 16'h0004, 32'h0,        4'h0, 8'h26, 1'b0, 32'hCAFEF00D};

    // Reset state
    #3;
    check("rst_ready_during", cmd_ready, 1'b1);
    check("rst_valid_during", resp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_ready_after", cmd_ready, 1'b1);
    check("rst_valid_after", resp_valid, 1'b0);

    // Give every word a known value
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, 1'b0, 16'(i * 4), $urandom(), 4'hF, 8'h00, 1'b0);
      tick();
    end
    idle();
    tick();

    // Vector table: exact 2-cycle read latency and strobe/alias behaviour
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, vecs[i].last);
      check($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
      tick();
      idle();
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_valid_n1", i), resp_valid, 1'b0);
        tick();
        check($sformatf("vec%0d_valid_n2", i), resp_valid, 1'b1);
        check($sformatf("vec%0d_data", i), resp_data, vecs[i].exp);
        check($sformatf("vec%0d_id", i), resp_id, vecs[i].id);
        check($sformatf("vec%0d_last", i), resp_last, vecs[i].last);
        tick();
      end
    end

    // 8-beat burst against a stalled response port
    resp_ready = 1'b0;
    n0 = n_resp; l0 = n_last;
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b1, 16'(b * 4), 32'h0, 4'h0, 8'h3C, 1'b0);
      tick();
    end
    idle();
    check("burst_ready_low", cmd_ready, 1'b0);
    repeat (3) tick();
    check("burst_hold_valid", resp_valid, 1'b1);
    check("burst_hold_ready", cmd_ready, 1'b0);
    resp_ready = 1'b1;
    for (int b = 4; b < 8; b++) begin
      drive(1'b0, 1'b1, 16'(b * 4), 32'h0, 4'h0, 8'h3C, b == 7);
      t = 0;
      while (!cmd_ready && t < 20) begin tick(); t++; end
      if (t >= 20) check("burst_ready_timeout", cmd_ready, 1'b1);
      tick();
    end
    drain("burst_drain");
    check("burst_count", n_resp - n0, 8);
    check("burst_last_count", n_last - l0, 1);

    // Back-to-back reads with the response port always ready
    n0 = n_resp;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 16'(k * 4), 32'h0, 4'h0, 8'(k), k == 15);
      check("b2b_ready", cmd_ready, 1'b1);
      tick();
    end
    idle();
    tick();
    tick();
    check("b2b_count", n_resp - n0, 16);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      drive(r < 4, r >= 4 && r < 8, 16'($urandom()), $urandom(), 4'($urandom()), 8'($urandom()), 1'($urandom()));
      cmd_auser = 1'($urandom());
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // Reset with three responses queued
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 16'(k * 4), 32'h0, 4'h0, 8'h50, 1'b0);
      tick();
    end
    idle();
    repeat (3) tick();
    check("rstq_valid_before", resp_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstq_valid_async", resp_valid, 1'b0);
    check("rstq_ready_async", cmd_ready, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    resp_ready = 1'b1;
    n0 = n_resp;
    repeat (10) tick();
    check("rstq_no_stale", n_resp - n0, 0);
    check("rstq_valid_after", resp_valid, 1'b0);
    check("rstq_ready_after", cmd_ready, 1'b1);

    // User resize on the RUSER_ENABLE=1 instance
    u2_auser = 4'hB; u2_id = 8'h77; u2_rd_en = 1'b1;
    tick();
    u2_auser = 4'h6; u2_id = 8'h78;
    tick();
    u2_rd_en = 1'b0;
    check("user_valid_b", u2_resp_valid, 1'b1);
    check("user_b", u2_resp_user, 2'h3);
    check("user_id_b", u2_resp_id, 8'h77);
    tick();
    check("user_6", u2_resp_user, 2'h2);
    check("user_id_6", u2_resp_id, 8'h78);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_ram_cmd_backend.md
Name: axi_ram_cmd_backend

Overview:
- RAM-side responder for the AXI RAM read/write interface.
- Consumes the shared RAM command stream (ram_cmd_*), performs byte-strobed writes and reads on an inferred single-port memory array, and returns read data on the ram_rd_resp_* stream.
- A credit-controlled response FIFO absorbs backpressure, so no read response is ever dropped.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, byte strobes per word
ID_WIDTH, 8, command/response ID width
AUSER_WIDTH, 1, ram_cmd_auser width
RUSER_ENABLE, 0, 1 = carry auser into ram_rd_resp_user
RUSER_WIDTH, 1, ram_rd_resp_user width
VALID_ADDR_WIDTH, ADDR_WIDTH-$clog2(STRB_WIDTH), word index bits; array depth is 2**VALID_ADDR_WIDTH
RESP_FIFO_DEPTH, 4, read response FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ram_cmd_id  in  ID_WIDTH  command ID
ram_cmd_addr  in  ADDR_WIDTH  byte address
ram_cmd_auser  in  AUSER_WIDTH  address user
ram_cmd_wr_data  in  DATA_WIDTH  write data
ram_cmd_wr_strb  in  STRB_WIDTH  write byte enables
ram_cmd_wr_en  in  1  write command valid
ram_cmd_rd_en  in  1  read command valid
ram_cmd_last  in  1  last beat of burst
ram_cmd_ready  out  1  command accept
ram_rd_resp_id  out  ID_WIDTH  response ID
ram_rd_resp_data  out  DATA_WIDTH  read data
ram_rd_resp_last  out  1  last beat
ram_rd_resp_user  out  RUSER_WIDTH  response user
ram_rd_resp_valid  out  1  response valid
ram_rd_resp_ready  in  1  response accept

Behaviour:
- Reset: rst_n low asynchronously clears the FIFO pointers, FIFO count, inflight flag and ram_rd_resp_valid.
  - ram_cmd_ready reads 1 during and immediately after reset.
  - Memory contents are not reset.
  - Response data/id/last/user are don't-care while valid=0.
- Word index: idx = ram_cmd_addr[$clog2(STRB_WIDTH) +: VALID_ADDR_WIDTH]. Upper address bits and byte-offset bits are ignored, so addresses alias modulo the array size.
- ram_cmd_ready = (fifo_count + inflight) < RESP_FIFO_DEPTH.
  - Registered state only; no combinational path from any *_en or ram_rd_resp_ready.
  - Applies to both reads and writes.
- Write accept (wr_en && ready), cycle N: each byte b with wr_strb[b]=1 is updated at the clk edge ending N; other bytes are kept. No response is generated. wr_data and auser are not used for responses.
- Read accept (rd_en && ready), cycle N:
  - Array read registered at the end of N; id, last and auser are captured alongside.
  - inflight=1 during N+1; the entry is pushed into the FIFO at the end of N+1.
  - ram_rd_resp_valid rises in N+2 at the earliest. Load-to-valid latency is 2 cycles.
- Read-after-write: a write in N followed by a read of the same idx in N+1 returns the new data.
- Both wr_en and rd_en high with ready: the write is performed and the read is ignored. Upstream guarantees mutual exclusion, so the bench flags this as an assertion error.
- FIFO:
  - Show-ahead: ram_rd_resp_* reflect the head entry.
  - Pop on ram_rd_resp_valid && ram_rd_resp_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Responses stay in command acceptance order.
  - valid stays asserted and outputs stay stable until accepted.
- ram_rd_resp_user = auser resized to RUSER_WIDTH (zero-extend or truncate) when RUSER_ENABLE=1, else 0.
- ram_cmd_last passes to ram_rd_resp_last unmodified for reads. There is no burst state inside this block.
- Throughput: with ram_rd_resp_ready held 1, one read per cycle is sustained indefinitely (count+inflight ≤ 2).
- Credit accounting is conservative: a pop in cycle N raises ready in N+1, not N.
- Reset mid-burst: queued and inflight responses are discarded, and no partial beats appear after release.

Test Plan:
- Write idx 5 = 0xAABBCCDD strb 0xF, then write 0x11223344 strb 0x5, then read idx 5 -> resp data 0xAA22CC44, last as driven, valid exactly 2 cycles after read accept.
- Read burst of 8 beats, ids 0x3C, last on beat 8, ram_rd_resp_ready held 0:
  - ready low after 4 accepts.
  - Then release ready -> 8 responses in order, data matches, last only on 8th, no loss or duplication.
- Back-to-back 16 reads with resp_ready=1 -> ready never drops, one response per cycle after 2-cycle fill.
- Address aliasing: write byte address 0x0004, read 0x0004 + (4 << VALID_ADDR_WIDTH) -> same data. Byte offset 0x0006 reads the same word as 0x0004.
- Assert rst_n low for 1 cycle with 3 responses queued -> ram_rd_resp_valid drops asynchronously, ready=1 after release, no stale responses emitted afterwards.
- RUSER_ENABLE=1, AUSER_WIDTH=4, RUSER_WIDTH=2, auser=0xB -> resp_user=0x3. With RUSER_ENABLE=0 -> resp_user=0.
